uart_rx: RTL and testbench

//  UART receiver for the serial line driven by uartTx: 8 data bits, no parity, 1 stop bit, LSB first.

---
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (LSB first) with a one-deep holding register,
// ready/rd handshake and sticky framing / overrun flags.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on the synchronised input
// START | counting to mid start bit, then confirming it is still low
// DATA  | sampling the 8 data bits at mid-bit, shifting them in LSB first
// STOP  | sampling the stop bit at mid-bit, committing or flagging the frame
// BREAK | stop bit was low, waiting for the line to return high
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       res,
  input  logic       serialIn,
  input  logic       rd,
  output logic [7:0] data,
  output logic       ready,
  output logic       frameError,
  output logic       overrun
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state_q;
  logic          sync1_q;
  logic          rxs_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    n_q;
  logic [7:0]    shreg_q;
  logic [7:0]    data_q;
  logic          ready_q;
  logic          frame_err_q;
  logic          overrun_q;

  assign data       = data_q;
  assign ready      = ready_q;
  assign frameError = frame_err_q;
  assign overrun    = overrun_q;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= serialIn;
      rxs_q   <= sync1_q;
    end
  end

  // Frame FSM plus holding register and flags; a commit in the same cycle as rd wins over the rd clear.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (rd) begin
        ready_q     <= 1'b0;
        frame_err_q <= 1'b0;
        overrun_q   <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (!rxs_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q   <= '0;
            n_q     <= '0;
            state_q <= rxs_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_BIT) begin
            cnt_q   <= '0;
            shreg_q <= {rxs_q, shreg_q[7:1]};
            if (n_q == 3'd7) begin
              state_q <= S_STOP;
            end else begin
              n_q <= n_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_BIT) begin
            cnt_q <= '0;
            if (rxs_q) begin
              state_q <= S_IDLE;
              if (!ready_q || rd) begin
                data_q  <= shreg_q;
                ready_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_BREAK: begin
          if (rxs_q) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into two receivers (434 clk/bit for the timing
// and glitch cases, 48 clk/bit for the rest); received bytes are checked by a
// queue-based scoreboard, flags and handshake by direct checks.
module tb_uart_rx;

  localparam int CPB   = 48;
  localparam int CPB_S = 434;

  logic       clk;
  logic       res;
  logic       ser;
  logic       rd;
  logic       ser_s;
  logic       rd_s;
  logic [7:0] data;
  logic [7:0] data_s;
  logic       ready;
  logic       fe;
  logic       ov;
  logic       ready_s;
  logic       fe_s;
  logic       ov_s;

  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic       done;
  logic       t3_done;
  logic       prev_ready;
  logic       prev_rd;
  int         lat;
  string      hello = "Hello World!";

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .res       (res),
    .serialIn  (ser),
    .rd        (rd),
    .data      (data),
    .ready     (ready),
    .frameError(fe),
    .overrun   (ov)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_S)) dut_slow (
    .clk       (clk),
    .res       (res),
    .serialIn  (ser_s),
    .rd        (rd_s),
    .data      (data_s),
    .ready     (ready_s),
    .frameError(fe_s),
    .overrun   (ov_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit slow, input logic v);
    if (slow) ser_s = v;
    else ser = v;
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit, input bit slow);
    int cpb = slow ? CPB_S : CPB;
    drive(slow, 1'b0);
    wait_cyc(cpb);
    for (int i = 0; i < 8; i++) begin
      drive(slow, b[i]);
      wait_cyc(cpb);
    end
    drive(slow, stop_bit);
    wait_cyc(cpb);
    drive(slow, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required finish before time limit");
    $fatal(1);
  end

  initial begin
    res = 1'b1; ser = 1'b1; rd = 1'b0; ser_s = 1'b1; rd_s = 1'b0;
    done = 1'b0; t3_done = 1'b0; prev_ready = 1'b0; prev_rd = 1'b0; lat = -1;
    fork
      begin : stim
        // T1: reset held while the line toggles
        for (int i = 0; i < 6; i++) begin
          @(posedge clk); #1;
          ser = ~ser;
          ser_s = ~ser_s;
        end
        ser = 1'b1; ser_s = 1'b1;
        @(negedge clk);
        chk("t1_data", 32'(data), 32'h00);
        chk("t1_ready", 32'(ready), 32'h0);
        chk("t1_frame_error", 32'(fe), 32'h0);
        chk("t1_overrun", 32'(ov), 32'h0);
        chk("t1_slow_ready", 32'(ready_s), 32'h0);
        chk("t1_slow_data", 32'(data_s), 32'h00);
        wait_cyc(1);
        res = 1'b0;
        wait_cyc(5);

        // T2: 0x48 at 434 clk/bit, latency from start edge to ready
        fork
          send(8'h48, 1'b1, 1'b1);
          begin
            for (int k = 0; k < 6000; k++) begin
              @(negedge clk);
              if (ready_s) begin
                lat = k;
                break;
              end
            end
          end
        join
        total_cnt++;
        if (lat >= 4123 && lat <= 4127) pass_cnt++;
        else $display("FAIL t2_latency: got %0d cycles, required 4125 +/- 2", lat);
        @(negedge clk);
        chk("t2_data", 32'(data_s), 32'h48);
        chk("t2_ready", 32'(ready_s), 32'h1);
        wait_cyc(1);
        rd_s = 1'b1;
        wait_cyc(1);
        rd_s = 1'b0;
        @(negedge clk);
        chk("t2_ready_after_rd", 32'(ready_s), 32'h0);

        // T3: "Hello World!" back to back, rd one cycle after each ready
        wait_cyc(2);
        fork
          begin
            for (int i = 0; i < 12; i++) begin
              exp_q.push_back(hello[i]);
              send(hello[i], 1'b1, 1'b0);
            end
            t3_done = 1'b1;
          end
          begin
            while (!t3_done) begin
              @(negedge clk);
              if (ready && !t3_done) begin
                wait_cyc(1);
                rd = 1'b1;
                wait_cyc(1);
                rd = 1'b0;
              end
            end
          end
        join
        wait_cyc(5);
        @(negedge clk);
        chk("t3_frame_error", 32'(fe), 32'h0);
        chk("t3_overrun", 32'(ov), 32'h0);
        chk("t3_ready_idle", 32'(ready), 32'h0);

        // T4: overrun, then clear, then a normal byte
        wait_cyc(1);
        exp_q.push_back(8'h55);
        send(8'h55, 1'b1, 1'b0);
        send(8'hAA, 1'b1, 1'b0);
        @(negedge clk);
        chk("t4_ovr_data", 32'(data), 32'h55);
        chk("t4_ovr_ready", 32'(ready), 32'h1);
        chk("t4_ovr_flag", 32'(ov), 32'h1);
        chk("t4_ovr_frame_error", 32'(fe), 32'h0);
        wait_cyc(1);
        rd = 1'b1;
        wait_cyc(1);
        rd = 1'b0;
        @(negedge clk);
        chk("t4_clr_ready", 32'(ready), 32'h0);
        chk("t4_clr_overrun", 32'(ov), 32'h0);
        chk("t4_clr_frame_error", 32'(fe), 32'h0);
        chk("t4_clr_data_kept", 32'(data), 32'h55);
        wait_cyc(1);
        exp_q.push_back(8'h0F);
        send(8'h0F, 1'b1, 1'b0);
        @(negedge clk);
        chk("t4_0f_ready", 32'(ready), 32'h1);
        chk("t4_0f_overrun", 32'(ov), 32'h0);
        wait_cyc(1);
        rd = 1'b1;
        wait_cyc(1);
        rd = 1'b0;
        // rd lands on the commit edge of the second byte (start + 3 + HALF + 9*CPB)
        exp_q.push_back(8'h55);
        send(8'h55, 1'b1, 1'b0);
        exp_q.push_back(8'hAA);
        fork
          send(8'hAA, 1'b1, 1'b0);
          begin
            wait_cyc(3 + CPB / 2 + 9 * CPB - 1);
            rd = 1'b1;
            wait_cyc(1);
            rd = 1'b0;
          end
        join
        @(negedge clk);
        chk("t4_align_data", 32'(data), 32'hAA);
        chk("t4_align_ready", 32'(ready), 32'h1);
        chk("t4_align_overrun", 32'(ov), 32'h0);
        wait_cyc(1);
        rd = 1'b1;
        wait_cyc(1);
        rd = 1'b0;

        // T5: low stop bit with the line held low for 3 more bit times
        wait_cyc(1);
        send(8'h3C, 1'b0, 1'b0);
        ser = 1'b0;
        wait_cyc(3 * CPB);
        ser = 1'b1;
        wait_cyc(10 * CPB);
        @(negedge clk);
        chk("t5_frame_error", 32'(fe), 32'h1);
        chk("t5_ready", 32'(ready), 32'h0);
        chk("t5_overrun", 32'(ov), 32'h0);
        wait_cyc(1);
        rd = 1'b1;
        wait_cyc(1);
        rd = 1'b0;
        @(negedge clk);
        chk("t5_fe_cleared", 32'(fe), 32'h0);
        wait_cyc(1);
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1, 1'b0);
        @(negedge clk);
        chk("t5_good_ready", 32'(ready), 32'h1);
        chk("t5_good_frame_error", 32'(fe), 32'h0);
        wait_cyc(1);
        rd = 1'b1;
        wait_cyc(1);
        rd = 1'b0;

        // T6: glitch rejection on both receivers
        wait_cyc(1);
        ser_s = 1'b0;
        wait_cyc(100);
        ser_s = 1'b1;
        wait_cyc(10 * CPB_S);
        @(negedge clk);
        chk("t6_glitch_ready", 32'(ready_s), 32'h0);
        chk("t6_glitch_frame_error", 32'(fe_s), 32'h0);
        chk("t6_glitch_overrun", 32'(ov_s), 32'h0);
        wait_cyc(1);
        ser = 1'b0;
        wait_cyc(10);
        ser = 1'b1;
        wait_cyc(CPB);
        chk("t6_fast_glitch_ready", 32'(ready), 32'h0);
        exp_q.push_back(8'hC3);
        send(8'hC3, 1'b1, 1'b0);
        @(negedge clk);
        chk("t6_c3_ready", 32'(ready), 32'h1);
        // reset mid-frame (during data bit 4), checked before the next clock edge
        wait_cyc(1);
        fork
          send(8'h5A, 1'b1, 1'b0);
          begin
            wait_cyc(3 + CPB / 2 + 4 * CPB + CPB / 2);
            #2;
            res = 1'b1;
            #1;
            chk("t6_async_data", 32'(data), 32'h00);
            chk("t6_async_ready", 32'(ready), 32'h0);
            chk("t6_async_frame_error", 32'(fe), 32'h0);
          end
        join
        wait_cyc(3);
        res = 1'b0;
        wait_cyc(5);
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        chk("t6_a5_ready", 32'(ready), 32'h1);
        chk("t6_a5_overrun", 32'(ov), 32'h0);
        wait_cyc(1);
        rd = 1'b1;
        wait_cyc(1);
        rd = 1'b0;
        @(negedge clk);
        chk("t6_a5_ready_after_rd", 32'(ready), 32'h0);
        chk("sb_all_consumed", 32'(exp_q.size()), 32'h0);
        done = 1'b1;
      end

      begin : monitor
        // A byte is presented when ready is seen high after being low, or
        // stays high across a cycle in which rd was taken (commit with rd).
        while (!done) begin
          @(negedge clk);
          if (res) begin
            prev_ready = 1'b0;
            prev_rd = 1'b0;
          end else begin
            if (ready && (!prev_ready || prev_rd)) begin
              if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected: got byte 0x%02h, required no byte", data);
              end else begin
                exp_b = exp_q.pop_front();
                chk("sb_data", 32'(data), 32'(exp_b));
              end
            end
            prev_ready = ready;
            prev_rd = rd;
          end
        end
      end
    join
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
